adc_test_pattern_gen: RTL

ADC_TEST_PATTERN_GEN -- requirements
Module: adc_test_pattern_gen

---
 rtl/adc_test_pkg.sv | 34 +++
 rtl/adc_lfsr_step.sv | 27 ++
 rtl/adc_test_pattern_gen.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/adc_test_pkg.sv
// Shared definitions for the ADC test-pattern generator: mode codes, PRBS
// polynomials/seeds and the default sample width.
package adc_test_pkg;

    localparam int ADC_DATA_W = 14;

    typedef enum logic [3:0] {
        MODE_ADC       = 4'h0,
        MODE_MIDSCALE  = 4'h1,
        MODE_FULLSCALE = 4'h2,
        MODE_ZERO      = 4'h3,
        MODE_CHECKER   = 4'h4,
        MODE_PN23      = 4'h5,
        MODE_PN9       = 4'h6,
        MODE_ONEZERO   = 4'h7,
        MODE_USER      = 4'h8,
        MODE_RAMP      = 4'hF
    } test_mode_e;

    // Control bits above the mode nibble
    localparam int PN23_HOLD_BIT = 4;
    localparam int PN9_HOLD_BIT  = 5;
    localparam int USER_CONT_BIT = 7;

    // Tap masks mark state bits (n-1) for each x^n term: x^23+x^18+1, x^9+x^5+1
    localparam int              PN23_W    = 23;
    localparam logic [22:0]     PN23_SEED = 23'h7F_FFFF;
    localparam logic [22:0]     PN23_TAPS = 23'h42_0000;

    localparam int              PN9_W     = 9;
    localparam logic [8:0]      PN9_SEED  = 9'h1FF;
    localparam logic [8:0]      PN9_TAPS  = 9'h110;

endpackage

// File: rtl/adc_lfsr_step.sv
// Combinational multi-shift step of a Fibonacci LFSR; the state shifts left
// and the first bit generated lands in the MSB of bits_out.
module adc_lfsr_step #(
    parameter int               WIDTH  = 9,
    parameter logic [WIDTH-1:0] TAPS   = '0,
    parameter int               SHIFTS = 14
) (
    input  logic [WIDTH-1:0]  state_in,
    output logic [WIDTH-1:0]  state_out,
    output logic [SHIFTS-1:0] bits_out
);

    always_comb begin : step_loop
        logic [WIDTH-1:0] s;
        logic             fb;
        s        = state_in;
        fb       = 1'b0;
        bits_out = '0;
        for (int i = 0; i < SHIFTS; i++) begin
            fb = ^(s & TAPS);
            s  = {s[WIDTH-2:0], fb};
            bits_out[SHIFTS-1-i] = fb;
        end
        state_out = s;
    end

endmodule

// File: rtl/adc_test_pattern_gen.sv
// ADC test-pattern generator: replaces the conversion data with a selectable
// test sequence, one registered offset-binary sample per ce.
module adc_test_pattern_gen
    import adc_test_pkg::*;
#(
    parameter int DATA_W = ADC_DATA_W
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              ce,
    input  logic [7:0]        test_mode,
    input  logic [15:0]       UserTestPattern1,
    input  logic [15:0]       UserTestPattern2,
    input  logic [15:0]       UserTestPattern3,
    input  logic [15:0]       UserTestPattern4,
    input  logic [DATA_W-1:0] adc_data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid
);

    // Alternating word with a 1 in the MSB (0x2AAA at 14 bits)
    function automatic logic [DATA_W-1:0] alt_word();
        logic [DATA_W-1:0] w;
        w = '0;
        for (int i = 0; i < DATA_W; i++) begin
            w[i] = ((DATA_W - 1 - i) % 2 == 0);
        end
        return w;
    endfunction

    localparam logic [DATA_W-1:0] MIDSCALE  = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] FULLSCALE = '1;
    localparam logic [DATA_W-1:0] ALT_A     = alt_word();
    localparam logic [DATA_W-1:0] ALT_B     = ~ALT_A;

    test_mode_e        mode;
    test_mode_e        prev_mode;
    logic              mode_changed;

    logic              phase_q, phase_eff, phase_d;
    logic [DATA_W-1:0] ramp_q, ramp_eff, ramp_d;
    logic [1:0]        idx_q, idx_eff, idx_d;

    logic [PN23_W-1:0] pn23_q, pn23_next, pn23_d;
    logic [PN9_W-1:0]  pn9_q, pn9_next, pn9_d;
    logic [DATA_W-1:0] pn23_bits, pn9_bits;

    logic [15:0]       user_word;
    logic [DATA_W-1:0] sample;

    logic              unused_bits;

    assign mode = test_mode_e'(test_mode[3:0]);

    // Bit 6 is reserved; user words are MSB-aligned so low bits may go unused
    assign unused_bits = ^{test_mode[6], UserTestPattern1, UserTestPattern2,
                           UserTestPattern3, UserTestPattern4};

    adc_lfsr_step #(
        .WIDTH  (PN23_W),
        .TAPS   (PN23_TAPS),
        .SHIFTS (DATA_W)
    ) u_pn23_step (
        .state_in  (pn23_q),
        .state_out (pn23_next),
        .bits_out  (pn23_bits)
    );

    adc_lfsr_step #(
        .WIDTH  (PN9_W),
        .TAPS   (PN9_TAPS),
        .SHIFTS (DATA_W)
    ) u_pn9_step (
        .state_in  (pn9_q),
        .state_out (pn9_next),
        .bits_out  (pn9_bits)
    );

    always_comb begin
        // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latches).
        mode_changed = (mode != prev_mode);
        phase_eff    = mode_changed ? 1'b0 : phase_q;
        ramp_eff     = mode_changed ? '0   : ramp_q;
        idx_eff      = mode_changed ? 2'd0 : idx_q;

        user_word = UserTestPattern1;
        case (idx_eff)
            2'd1:    user_word = UserTestPattern2;
            2'd2:    user_word = UserTestPattern3;
            2'd3:    user_word = UserTestPattern4;
            default: user_word = UserTestPattern1;
        endcase

        sample  = MIDSCALE;
        phase_d = phase_eff;
        ramp_d  = ramp_eff;
        idx_d   = idx_eff;
        pn23_d  = pn23_q;
        pn9_d   = pn9_q;

        case (mode)
            MODE_ADC:       sample = adc_data_in;
            MODE_MIDSCALE:  sample = MIDSCALE;
            MODE_FULLSCALE: sample = FULLSCALE;
            MODE_ZERO:      sample = '0;
            MODE_CHECKER: begin
                sample = phase_eff ? ALT_B : ALT_A;
                if (ce) phase_d = ~phase_eff;
            end
            MODE_ONEZERO: begin
                sample = phase_eff ? '0 : FULLSCALE;
                if (ce) phase_d = ~phase_eff;
            end
            MODE_PN23: begin
                sample = pn23_bits;
                if (ce) pn23_d = pn23_next;
            end
            MODE_PN9: begin
                sample = pn9_bits;
                if (ce) pn9_d = pn9_next;
            end
            MODE_USER: begin
                sample = user_word[15 -: DATA_W];
                if (ce) begin
                    if (idx_eff == 2'd3) idx_d = test_mode[USER_CONT_BIT] ? 2'd0 : 2'd3;
                    else                 idx_d = idx_eff + 2'd1;
                end
            end
            MODE_RAMP: begin
                sample = ramp_eff;
                if (ce) ramp_d = ramp_eff + DATA_W'(1);
            end
            default: sample = MIDSCALE;
        endcase

        // Hold bits pin the generators to their seeds regardless of ce or mode
        if (test_mode[PN23_HOLD_BIT]) pn23_d = PN23_SEED;
        if (test_mode[PN9_HOLD_BIT])  pn9_d  = PN9_SEED;
    end

    always_ff @(posedge clk or negedge resetn) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
        if (!resetn) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            prev_mode  <= MODE_ADC;
            phase_q    <= 1'b0;
            ramp_q     <= '0;
            idx_q      <= 2'd0;
            pn23_q     <= PN23_SEED;
            pn9_q      <= PN9_SEED;
        end else begin
            data_valid <= ce;
            if (ce) data_out <= sample;
            prev_mode  <= mode;
            phase_q    <= phase_d;
            ramp_q     <= ramp_d;
            idx_q      <= idx_d;
            pn23_q     <= pn23_d;
            pn9_q      <= pn9_d;
        end
    end

endmodule
